// File: rtl/call_ret_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// call_ret_pkg : shared state type, depth-width helper and trap default.
// Rev 1.0
// ----------------------------------------------------------------------------
package call_ret_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Bits needed to hold an occupancy in 0..max_depth inclusive.
  function automatic int depth_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  localparam logic [15:0] c_trap_vector_default = 16'h0004;

endpackage
`default_nettype wire

// File: rtl/sat_updown_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_updown_ctr : up/down counter saturating at 0 and MAX.
// Rev 1.0
// ----------------------------------------------------------------------------
module sat_updown_ctr
  import call_ret_pkg::*;
#(
  parameter int MAX = 100,
  parameter int W   = depth_w(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_count;
  logic         w_full;
  logic         w_empty;

  assign w_full  = (r_count == W'(MAX));
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && !w_empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/call_ret_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// call_ret_ctrl : CALL/RET control in front of the return-address stack.
// Optional CALL_RET_TRAP_EN redirects stack over/underflow to TRAP_VECTOR. Rev 1.0
// ----------------------------------------------------------------------------
module call_ret_ctrl
  import call_ret_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 100,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(c_trap_vector_default)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_call,
  input  logic                      i_ret,
  input  logic [WIDTH-1:0]          i_pc,
  input  logic [WIDTH-1:0]          i_target,
  output logic [WIDTH-1:0]          o_stk_data,
  output logic                      o_stk_push,
  output logic                      o_stk_pop,
  input  logic [WIDTH-1:0]          i_stk_out,
  output logic                      o_pc_load,
  output logic [WIDTH-1:0]          o_pc_next,
  output logic                      o_stall,
  output logic [depth_w(DEPTH)-1:0] o_depth,
  output logic                      o_err_ovf,
  output logic                      o_err_udf
);

  localparam int DW = depth_w(DEPTH);

`ifdef CALL_RET_TRAP_EN
  localparam logic c_trap_en = 1'b1;
`else
  localparam logic c_trap_en = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_stk_data, w_stk_data;
  logic [WIDTH-1:0] r_pc_next, w_pc_next;
  logic             r_push, w_push;
  logic             r_pop, w_pop;
  logic             r_load, w_load;
  logic             r_stall, w_stall;
  logic             r_ovf, w_ovf;
  logic             r_udf, w_udf;
  logic             w_inc, w_dec;
  logic             w_full, w_empty;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_ovf_pc;
  logic [WIDTH-1:0] w_udf_pc;

  assign w_pc_inc = i_pc + 1'b1;
  assign w_ovf_pc = c_trap_en ? TRAP_VECTOR : i_target;
  assign w_udf_pc = c_trap_en ? TRAP_VECTOR : w_pc_inc;

  sat_updown_ctr #(
    .MAX (DEPTH),
    .W   (DW)
  ) u_depth (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_count (o_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Call wins over a simultaneous ret; strobes are ignored outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_stk_data  = r_stk_data;
    w_pc_next   = r_pc_next;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_ovf       = r_ovf;
    w_udf       = r_udf;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_call) begin
          w_load = 1'b1;
          if (w_full) begin
            w_ovf     = 1'b1;
            w_pc_next = w_ovf_pc;
          end else begin
            w_push     = 1'b1;
            w_stk_data = w_pc_inc;
            w_pc_next  = i_target;
            w_inc      = 1'b1;
          end
        end else if (i_ret) begin
          if (w_empty) begin
            w_udf     = 1'b1;
            w_load    = 1'b1;
            w_pc_next = w_udf_pc;
          end else begin
            w_pop       = 1'b1;
            w_dec       = 1'b1;
            w_state_nxt = POP;
          end
        end
      end
      POP: begin
        w_state_nxt = LOAD;
      end
      LOAD: begin
        // Stack data became valid during this state.
        w_load      = 1'b1;
        w_pc_next   = i_stk_out;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_stall = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stk_data <= '0;
      r_pc_next  <= '0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_load     <= 1'b0;
      r_stall    <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stk_data <= w_stk_data;
      r_pc_next  <= w_pc_next;
      r_push     <= w_push;
      r_pop      <= w_pop;
      r_load     <= w_load;
      r_stall    <= w_stall;
      r_ovf      <= w_ovf;
      r_udf      <= w_udf;
    end
  end

  assign o_stk_data = r_stk_data;
  assign o_stk_push = r_push;
  assign o_stk_pop  = r_pop;
  assign o_pc_load  = r_load;
  assign o_pc_next  = r_pc_next;
  assign o_stall    = r_stall;
  assign o_err_ovf  = r_ovf;
  assign o_err_udf  = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_call_ret_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_call_ret_ctrl : scoreboard bench for call_ret_ctrl with a behavioural stack.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_call_ret_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_call, i_ret;
  logic [15:0] i_pc, i_target;
  logic [15:0] o_stk_data, stk_out, o_pc_next;
  logic        o_stk_push, o_stk_pop, o_pc_load, o_stall, o_err_ovf, o_err_udf;
  logic [6:0]  o_depth;

  always #5 clk = ~clk;

  call_ret_ctrl #(.WIDTH(16), .DEPTH(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_call     (i_call),
    .i_ret      (i_ret),
    .i_pc       (i_pc),
    .i_target   (i_target),
    .o_stk_data (o_stk_data),
    .o_stk_push (o_stk_push),
    .o_stk_pop  (o_stk_pop),
    .i_stk_out  (stk_out),
    .o_pc_load  (o_pc_load),
    .o_pc_next  (o_pc_next),
    .o_stall    (o_stall),
    .o_depth    (o_depth),
    .o_err_ovf  (o_err_ovf),
    .o_err_udf  (o_err_udf)
  );

  // Behavioural return-address stack: registered read the cycle after pop.
  logic [15:0] stk_mem [0:127];
  int          stk_sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_sp = 0;
      stk_out <= '0;
    end else begin
      if (o_stk_push && stk_sp < 128) begin
        stk_mem[stk_sp] = o_stk_data;
        stk_sp = stk_sp + 1;
      end
      if (o_stk_pop && stk_sp > 0) begin
        stk_sp = stk_sp - 1;
        stk_out <= stk_mem[stk_sp];
      end
    end
  end

  typedef struct {
    string       name;
    logic        push, pop, load, stall, ovf, udf;
    logic [15:0] data, pcn;
    logic [6:0]  depth;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_stk[$];
  int          m_depth = 0;
  logic        m_ovf = 1'b0, m_udf = 1'b0;
  int          total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] errpc(input logic [15:0] n);
`ifdef CALL_RET_TRAP_EN
    return 16'h0004;
`else
    return n;
`endif
  endfunction

  // Monitor: every push/pop/redirect strobe must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (o_stk_push || o_stk_pop || o_pc_load)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: push=%0b pop=%0b load=%0b pc_next=%0h, expected no event",
                 o_stk_push, o_stk_pop, o_pc_load, o_pc_next);
      end else begin
        e = q.pop_front();
        chk({e.name, "/push"},  32'(o_stk_push), 32'(e.push));
        chk({e.name, "/pop"},   32'(o_stk_pop),  32'(e.pop));
        chk({e.name, "/load"},  32'(o_pc_load),  32'(e.load));
        chk({e.name, "/stall"}, 32'(o_stall),    32'(e.stall));
        chk({e.name, "/depth"}, 32'(o_depth),    32'(e.depth));
        chk({e.name, "/ovf"},   32'(o_err_ovf),  32'(e.ovf));
        chk({e.name, "/udf"},   32'(o_err_udf),  32'(e.udf));
        if (e.push) chk({e.name, "/data"}, 32'(o_stk_data), 32'(e.data));
        if (e.load) chk({e.name, "/pc_next"}, 32'(o_pc_next), 32'(e.pcn));
      end
    end
  end

  task automatic do_call(input string nm, input logic [15:0] pc, input logic [15:0] tgt,
                         input logic with_ret);
    exp_t e;
    @(negedge clk);
    i_call = 1'b1; i_ret = with_ret; i_pc = pc; i_target = tgt;
    e.name = nm; e.pop = 1'b0; e.load = 1'b1; e.stall = 1'b0;
    e.data = pc + 16'd1;
    if (m_depth < 100) begin
      e.push = 1'b1; e.pcn = tgt;
      m_depth++;
      m_stk.push_back(pc + 16'd1);
    end else begin
      e.push = 1'b0; e.pcn = errpc(tgt);
      m_ovf = 1'b1;
    end
    e.depth = 7'(m_depth); e.ovf = m_ovf; e.udf = m_udf;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_call = 1'b0; i_ret = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ret(input string nm, input logic [15:0] pc, input logic abort);
    exp_t e;
    @(negedge clk);
    i_call = 1'b0; i_ret = 1'b1; i_pc = pc;
    e.name = nm; e.push = 1'b0; e.data = '0;
    if (m_depth > 0) begin
      m_depth--;
      e.pop = 1'b1; e.load = 1'b0; e.stall = 1'b1; e.pcn = '0;
      e.depth = 7'(m_depth); e.ovf = m_ovf; e.udf = m_udf;
      q.push_back(e);
      e.pop = 1'b0; e.load = 1'b1; e.stall = 1'b0; e.pcn = m_stk.pop_back();
      if (!abort) q.push_back(e);
      @(negedge clk);
      i_ret = 1'b0;
      if (abort) return;
      chk({nm, "/stall_load"}, 32'(o_stall), 32'd1);
      repeat (2) @(negedge clk);
    end else begin
      m_udf = 1'b1;
      e.pop = 1'b0; e.load = 1'b1; e.stall = 1'b0; e.pcn = errpc(pc + 16'd1);
      e.depth = 7'(m_depth); e.ovf = m_ovf; e.udf = m_udf;
      q.push_back(e);
      @(negedge clk);
      i_ret = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk({nm, "/no_stall"}, 32'(o_stall), 32'd0);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_call = 1'b0; i_ret = 1'b0; i_pc = '0; i_target = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst/push",    32'(o_stk_push), 32'd0);
    chk("rst/pop",     32'(o_stk_pop),  32'd0);
    chk("rst/load",    32'(o_pc_load),  32'd0);
    chk("rst/stall",   32'(o_stall),    32'd0);
    chk("rst/depth",   32'(o_depth),    32'd0);
    chk("rst/ovf",     32'(o_err_ovf),  32'd0);
    chk("rst/udf",     32'(o_err_udf),  32'd0);
    chk("rst/data",    32'(o_stk_data), 32'd0);
    chk("rst/pc_next", 32'(o_pc_next),  32'd0);

    do_call("call1", 16'h0010, 16'h0200, 1'b0);
    idle(2);
    do_ret("ret1", 16'h0200, 1'b0);
    do_ret("udf", 16'h0040, 1'b0);

    do_call("callA", 16'h0100, 16'h0500, 1'b0);
    do_call("callB", 16'h0101, 16'h0501, 1'b0);
    do_call("call_ret", 16'h0102, 16'h0502, 1'b1);
    idle(3);
    chk("call_ret/depth_after", 32'(o_depth), 32'd3);

    for (int i = 3; i < 100; i++)
      do_call("fill", 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
    do_call("ovf", 16'h0050, 16'h0300, 1'b0);
    idle(2);
    chk("ovf/depth_after", 32'(o_depth), 32'd100);

    do_ret("ret_top", 16'h0060, 1'b0);

    // Reset lands while the controller sits in POP.
    do_ret("ret_abort", 16'h0061, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort/stall", 32'(o_stall),   32'd0);
    chk("abort/load",  32'(o_pc_load), 32'd0);
    chk("abort/depth", 32'(o_depth),   32'd0);
    chk("abort/ovf",   32'(o_err_ovf), 32'd0);
    m_depth = 0; m_ovf = 1'b0; m_udf = 1'b0; m_stk.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort/stall_after", 32'(o_stall), 32'd0);

    do_call("post_rst", 16'h0070, 16'h0080, 1'b0);
    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
